// File: rtl/fa_using_fs_unit_if.sv
// Operand/result bundle for the registered full-subtractor-based adder.
// The master drives operands and observes the registered result.
interface fa_using_fs_unit_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;

  modport master (
    output in_valid, a, b, c,
    input  sum, cout, out_valid
  );

  modport slave (
    input  in_valid, a, b, c,
    output sum, cout, out_valid
  );
endinterface

// File: rtl/fa_using_fs_unit.sv
// Registered ripple-carry adder whose bit cells are built purely from full-subtractor
// primitives: {cout, sum} = a + b + c with one cycle of latency.
module fa_using_fs_unit #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  fa_using_fs_unit_if.slave  bus
);

  // Full-subtractor outputs: difference and borrow-out.
  function automatic logic fs_diff(input logic x, input logic y, input logic bin);
    fs_diff = x ^ y ^ bin;
  endfunction

  function automatic logic fs_bout(input logic x, input logic y, input logic bin);
    fs_bout = (~x & y) | (~x & bin) | (y & bin);
  endfunction

  logic [WIDTH:0]   ci;
  logic [WIDTH-1:0] s;

  // Borrow of (~a - b - ci) is the majority of a, b, ci, i.e. the adder carry.
  always_comb begin
    ci    = '0;
    s     = '0;
    ci[0] = bus.c;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]    = fs_diff(bus.a[i], bus.b[i], ci[i]);
      ci[i+1] = fs_bout(~bus.a[i], bus.b[i], ci[i]);
    end
  end

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             vld_q, vld_d;

  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    vld_d  = 1'b0;
    if (bus.in_valid) begin
      sum_d  = s;
      cout_d = ci[WIDTH];
      vld_d  = 1'b1;
    end
  end

  // Result register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      vld_q  <= vld_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_fa_using_fs_unit.sv
// Directed bench for fa_using_fs_unit at WIDTH 1, 4 and 8 with hand-computed
// expectations and a randomized WIDTH=8 stream checked against a+b+c.
module tb_fa_using_fs_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fa_using_fs_unit_if #(.WIDTH(1)) if1 ();
  fa_using_fs_unit_if #(.WIDTH(4)) if4 ();
  fa_using_fs_unit_if #(.WIDTH(8)) if8 ();

  fa_using_fs_unit #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  fa_using_fs_unit #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  fa_using_fs_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic v, input logic a, input logic b, input logic c);
    @(negedge clk);
    if1.in_valid = v; if1.a = a; if1.b = b; if1.c = c;
  endtask

  task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clk);
    if4.in_valid = v; if4.a = a; if4.b = b; if4.c = c;
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    if8.in_valid = v; if8.a = a; if8.b = b; if8.c = c;
  endtask

  logic [1:0] fa_tbl [8];
  logic [7:0] ra, rb;
  logic       rc, rv;
  logic [8:0] exp8;
  logic       expv;

  initial begin
    fa_tbl = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.c = 1'b0;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.c = 1'b0;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.c = 1'b0;

    // Initial reset of all instances
    tick(); tick();
    check("rst_w1_out", {if1.out_valid, if1.cout, if1.sum}, 64'h0);
    check("rst_w4_out", {if4.out_valid, if4.cout, if4.sum}, 64'h0);
    check("rst_w8_out", {if8.out_valid, if8.cout, if8.sum}, 64'h0);
    @(negedge clk); rst = 1'b0;

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      drive1(1'b1, i[2], i[1], i[0]);
      tick();
      check($sformatf("w1_exh_%0d_cs", i), {if1.cout, if1.sum}, 64'(fa_tbl[i]));
      check($sformatf("w1_exh_%0d_vld", i), if1.out_valid, 64'h1);
    end

    // Reset held two cycles while a valid op is presented
    drive1(1'b1, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    check("w1_rst_c1", {if1.out_valid, if1.cout, if1.sum}, 64'h0);
    tick();
    check("w1_rst_c2", {if1.out_valid, if1.cout, if1.sum}, 64'h0);
    @(negedge clk); rst = 1'b0;
    tick();
    check("w1_post_rst_cs", {if1.cout, if1.sum}, 64'h3);
    check("w1_post_rst_vld", if1.out_valid, 64'h1);

    // Hold on idle, including X operands while in_valid is low
    drive1(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check("w1_hold_setup", {if1.out_valid, if1.cout, if1.sum}, 64'h6);
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("w1_hold_1", {if1.out_valid, if1.cout, if1.sum}, 64'h2);
    drive1(1'b0, 1'bx, 1'bx, 1'bx);
    tick();
    check("w1_hold_x", {if1.out_valid, if1.cout, if1.sum}, 64'h2);
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("w1_hold_3", {if1.out_valid, if1.cout, if1.sum}, 64'h2);

    // WIDTH=4 wrap-around cases
    drive4(1'b1, 4'd15, 4'd15, 1'b1);
    tick();
    check("w4_ff_ff_1", {if4.out_valid, if4.cout, if4.sum}, {58'h0, 1'b1, 1'b1, 4'd15});
    drive4(1'b1, 4'd15, 4'd0, 1'b1);
    tick();
    check("w4_f_0_1", {if4.out_valid, if4.cout, if4.sum}, {58'h0, 1'b1, 1'b1, 4'd0});
    drive4(1'b1, 4'd7, 4'd8, 1'b0);
    tick();
    check("w4_7_8_0", {if4.out_valid, if4.cout, if4.sum}, {58'h0, 1'b1, 1'b0, 4'd15});

    // WIDTH=4 mid-stream reset drops the coincident op
    drive4(1'b1, 4'd2, 4'd3, 1'b0);
    tick();
    check("w4_ms_pre", {if4.out_valid, if4.cout, if4.sum}, {58'h0, 1'b1, 1'b0, 4'd5});
    drive4(1'b1, 4'd3, 4'd4, 1'b0);
    rst = 1'b1;
    tick();
    check("w4_ms_drop", {if4.out_valid, if4.cout, if4.sum}, 64'h0);
    drive4(1'b1, 4'd1, 4'd1, 1'b0);
    rst = 1'b0;
    tick();
    check("w4_ms_post", {if4.out_valid, if4.cout, if4.sum}, {58'h0, 1'b1, 1'b0, 4'd2});

    // WIDTH=8 known op, then random stream with toggling in_valid
    drive8(1'b1, 8'd200, 8'd100, 1'b1);
    tick();
    check("w8_seed", {if8.out_valid, if8.cout, if8.sum}, {54'h0, 1'b1, 9'h12D});
    exp8 = 9'h12D;
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1));
      drive8(rv, ra, rb, rc);
      if (rv) exp8 = {1'b0, ra} + {1'b0, rb} + {8'h0, rc};
      expv = rv;
      tick();
      check($sformatf("w8_rnd_%0d_cs", k), {if8.cout, if8.sum}, {55'h0, exp8});
      check($sformatf("w8_rnd_%0d_vld", k), if8.out_valid, {63'h0, expv});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fa_using_fs_unit.md
Name: fa_using_fs_unit

Overview:
- Registered ripple-carry adder in which every bit cell is a full adder built only from full-subtractor primitives plus an input inverter.
- Used as a datapath arithmetic leaf and as a structural proof that full-subtractor cells can implement addition.
- Computes {cout, sum} = a + b + c for WIDTH-bit operands and registers the result with one-cycle latency.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  a, b, c are sampled on this cycle.
- a  input  WIDTH  addend A.
- b  input  WIDTH  addend B.
- c  input  1  carry-in to bit 0.
- sum  output  WIDTH  registered sum bits.
- cout  output  1  registered carry-out of bit WIDTH-1.
- out_valid  output  1  sum/cout updated on the previous edge.

Behaviour:
- One clock (clk) and one reset (rst). Reset is synchronous and active-high. It is sampled only on the rising edge of clk.
- Full-subtractor primitive (fs): inputs x, y, bin; outputs diff = x^y^bin and bout = (~x&y)|(~x&bin)|(y&bin).
- Bit cell i uses two fs instances:
  - FS_S(x=a[i], y=b[i], bin=ci) gives s[i] = diff.
  - FS_C(x=~a[i], y=b[i], bin=ci) gives co[i] = bout, which equals the majority of a[i], b[i], ci.
- No "+" operator or behavioural adder is allowed in the bit cells.
- Ripple chain: ci of bit 0 = c; ci of bit i = co[i-1]; combinational cout = co[WIDTH-1].
- Arithmetic: {cout, sum} = a + b + c computed modulo 2^(WIDTH+1). The all-ones case a = b = 2^WIDTH-1 with c = 1 yields sum = 2^WIDTH-1, cout = 1. No overflow flag.
- Register stage, on each rising clk edge:
  - If rst = 1: sum <= 0, cout <= 0, out_valid <= 0. This overrides in_valid.
  - Else if in_valid = 1: sum <= s, cout <= co[WIDTH-1], out_valid <= 1.
  - Else: sum and cout hold their previous values; out_valid <= 0.
- Latency: exactly 1 cycle from sampled in_valid to out_valid.
- Throughput: one new operation per cycle. Back-to-back in_valid produces back-to-back out_valid.
- Reset mid-operation: an operation sampled on the same edge as rst = 1 is discarded. The first valid result after reset needs in_valid high on an edge with rst = 0.
- Before the first reset, output values are undefined. The bench must assert rst for at least 1 cycle.
- X on a, b, or c with in_valid = 0 must not corrupt the held outputs.

Test Plan:
- WIDTH=1 exhaustive, in_valid=1. Drive (a,b,c) = 000, 001, 010, 011, 100, 101, 110, 111 on successive cycles. Required (cout,sum) one cycle later: 00, 01, 01, 10, 01, 10, 10, 11, each with out_valid=1.
- Reset behaviour: hold rst=1 for 2 cycles while in_valid=1, a=1, b=1, c=1. Required: sum=0, cout=0, out_valid=0 throughout. Release rst; the next edge yields sum=1, cout=1.
- Hold on idle: after a=1, b=0, c=1 (sum=0, cout=1), set in_valid=0 for 3 cycles with a=0, b=0, c=0. Required: sum=0 and cout=1 hold; out_valid=0.
- WIDTH=4 wrap-around: a=15, b=15, c=1 gives sum=15, cout=1. a=15, b=0, c=1 gives sum=0, cout=1. a=7, b=8, c=0 gives sum=15, cout=0.
- WIDTH=8 random: 1000 random a, b, c with in_valid toggling randomly. Compare {cout,sum} to a+b+c delayed one cycle. out_valid must equal in_valid delayed one cycle.
- Mid-stream reset, WIDTH=4: stream of valid ops; assert rst for one cycle coincident with a=3, b=4, c=0. Required: that op is dropped (out_valid=0, sum=0, cout=0). The following op a=1, b=1, c=0 gives sum=2.
